ahb_bist_master: RTL and testbench
==================================

Name: ahb_bist_master

Overview:
- AHB-Lite master traffic engine that sits directly upstream of the AHB SRAM wrapper, driving its slave port.
- On a start pulse it fills a word range with a generated pattern, read-checks that range against the regenerated pattern, or does both in sequence.
- It reports pass/fail, mismatch count and first failing address.
- Used for memory bring-up and regression in place of the behavioural master model.

Parameters:
- ADDR_BITS, 12, byte-address width of haddr_o; matches the slave's mem_abit+2.
- DATA_WIDTH, 32, bus data width; fixed at 32, word transfers only.
- LEN_BITS, 11, width of len_words_i; maximum length is 2^(ADDR_BITS-2) words.

Ports:
- hclk_i  in  1  bus clock.
- hrst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- mode_i  in  2  0=write, 1=read-check, 2=write-then-check, 3=treated as 0.
- pat_sel_i  in  2  0=address, 1=~address, 2=constant seed, 3=LFSR.
- seed_i  in  32  pattern seed.
- base_addr_i  in  ADDR_BITS  word-aligned start byte address; bits[1:0] ignored.
- len_words_i  in  LEN_BITS  number of words.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky: mismatch or bus error in last run.
- bus_err_o  out  1  sticky: last run aborted by HRESP ERROR.
- err_cnt_o  out  16  mismatch count, saturating at 0xFFFF.
- first_err_addr_o  out  ADDR_BITS  address of first mismatch.
- hsel_o  out  1  slave select.
- haddr_o  out  ADDR_BITS  address.
- htrans_o  out  2  transfer type.
- hburst_o  out  3  burst type, SINGLE or INCR4.
- hsize_o  out  3  transfer size; constant 3'b010.
- hprot_o  out  4  protection; constant 4'b0011.
- hwrite_o  out  1  direction.
- hwdata_o  out  32  write data.
- hready_i  in  1  slave hreadyout; integration ties the slave's hready_i to the same net.
- hrdata_i  in  32  read data.
- hresp_i  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values: every output is 0, except hsize_o=3'b010 and hprot_o=4'b0011. Reset takes effect immediately (async) and aborts any transfer: htrans_o=IDLE, hsel_o=0.
- FSM states:
  - IDLE -> ADDR on start_i, or -> DONE when len_words_i=0 (no bus traffic).
  - ADDR -> DRAIN once the last address phase is accepted.
  - DRAIN -> TURN when mode=2 and on the write pass; otherwise -> DONE.
  - TURN: one IDLE cycle, reload address/count/pattern, then -> ADDR with hwrite_o=0.
  - DONE: done_o=1 for one cycle, busy_o falls in the same cycle, then -> IDLE.
- start_i clears err_o, bus_err_o, err_cnt_o and first_err_addr_o, and latches all inputs.
- Address/data pipelining:
  - An address phase is accepted on a rising edge with hready_i=1.
  - Data phase n is concurrent with address phase n+1.
  - hwdata_o is presented in the cycle after its address is accepted and held until hready_i=1.
  - While hready_i=0, haddr/htrans/hburst/hwrite/hwdata are held stable.
- Burst selection, evaluated at each burst start:
  - INCR4 when haddr[3:0]=0 and remaining>=4. htrans_o is NONSEQ, SEQ, SEQ, SEQ, address +4 per beat; an INCR4 never crosses a 1 KB boundary.
  - Otherwise SINGLE with NONSEQ.
  - Back-to-back bursts have no IDLE gap.
- Address wraps modulo 2^ADDR_BITS.
- Patterns, one value per word in order:
  - address: byte address zero-extended.
  - ~address: its inverse.
  - constant: seed_i.
  - LFSR: 32-bit Galois, polynomial 0x80200003. Seeded with seed_i; seed 0 is replaced by 1. Advances once per word.
- Read check:
  - On each completed read data phase (hready_i=1), compare hrdata_i with the expected pattern.
  - On mismatch, increment err_cnt_o and set err_o.
  - The first mismatch latches its address into first_err_addr_o.
- ERROR response:
  - On the first ERROR cycle (hresp_i=1, hready_i=0), drive htrans_o=IDLE in the next cycle and cancel remaining beats.
  - Set bus_err_o and err_o, then go to DONE.
- hsel_o=1 exactly while in ADDR or DRAIN. htrans_o=IDLE in all other states.

Decomposition:
- Package ahb_bist_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HBURST_SINGLE/INCR4.
  - HSIZE_WORD, HPROT_DEFAULT.
  - Mode and pattern encodings.
  - LFSR_POLY.
  - The FSM state typedef.
- Sub-module ahb_bist_patgen (load, advance, pattern select, seed, address in; data out) is instantiated twice: once for the write-data stream and once for the expected-read stream.

Test Plan:
- mode=2, pat=address, base=0x000, len=8 -> two INCR4 bursts (NONSEQ@0x000, SEQ@0x004..0x00C; NONSEQ@0x010..). SRAM word k holds 4k. err_cnt_o=0, done_o pulses once.
- mode=0, pat=LFSR, seed=0, base=0x004, len=5 -> five SINGLE transfers at 0x004..0x014 carrying the LFSR sequence starting from 1. Then mode=1 with the same settings -> err_o=0.
- Write-then-check, pat=constant 0xA5A5A5A5, len=16; backdoor-corrupt word 0x020 between passes -> err_cnt_o=1, first_err_addr_o=0x020, err_o=1.
- Slave holds hreadyout low for 2 cycles mid-INCR4 -> haddr/htrans/hwdata stable for those cycles, no beat lost, final data correct.
- Slave returns ERROR on 3rd beat -> next cycle htrans_o=IDLE, bus_err_o=1, done_o pulse, no further NONSEQ. Also len=0 -> done_o one cycle after start, hsel_o never asserted.
- Assert hrst_i mid-burst -> same cycle htrans_o=IDLE, busy_o=0; a new start after release runs normally.

Source files
------------

// File: rtl/ahb_bist_pkg.sv
// Shared encodings for the AHB BIST master: bus constants, mode/pattern codes,
// FSM states and the pattern LFSR step.
package ahb_bist_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_WRITE = 2'd0,
        MODE_READ  = 2'd1,
        MODE_WRCHK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'd0,
        PAT_NADDR = 2'd1,
        PAT_CONST = 2'd2,
        PAT_LFSR  = 2'd3
    } pat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DRAIN,
        S_TURN,
        S_DONE
    } state_t;

    // Right-shifting Galois step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ahb_bist_patgen.sv
// Pattern stream generator: one word per advance, derived from the word's
// byte address, the seed, or a free-running LFSR.
module ahb_bist_patgen
    import ahb_bist_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 adv,
    input  pat_t                 pat_sel,
    input  logic [31:0]          seed,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [31:0]          data
);

    pat_t        pat_q;
    logic [31:0] seed_q;
    logic [31:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_ADDR;
            seed_q <= '0;
            lfsr_q <= 32'd1;
        end else if (load) begin
            pat_q  <= pat_sel;
            seed_q <= seed;
            lfsr_q <= (seed == '0) ? 32'd1 : seed;
        end else if (adv) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        data = '0;
        case (pat_q)
            PAT_ADDR:  data = 32'(addr);
            PAT_NADDR: data = ~32'(addr);
            PAT_CONST: data = seed_q;
            PAT_LFSR:  data = lfsr_q;
        endcase
    end

endmodule

// File: rtl/ahb_bist_master.sv
// AHB-Lite BIST master: fills a word range with a pattern and/or read-checks it,
// reporting mismatch count, first failing address and bus errors.
module ahb_bist_master
    import ahb_bist_pkg::*;
#(
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_BITS   = 11
) (
    input  logic                  hclk_i,
    input  logic                  hrst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [1:0]            pat_sel_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [ADDR_BITS-1:0]  base_addr_i,
    input  logic [LEN_BITS-1:0]   len_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  bus_err_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_BITS-1:0]  first_err_addr_o,
    output logic                  hsel_o,
    output logic [ADDR_BITS-1:0]  haddr_o,
    output logic [1:0]            htrans_o,
    output logic [2:0]            hburst_o,
    output logic [2:0]            hsize_o,
    output logic [3:0]            hprot_o,
    output logic                  hwrite_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic                  hready_i,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hresp_i
);

    state_t                state;
    mode_t                 mode_q;
    pat_t                  pat_q;
    logic [31:0]           seed_q;
    logic [ADDR_BITS-1:0]  base_q;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS-1:0]   addr_left;
    logic [1:0]            beat_left;
    logic                  dp_valid;
    logic                  dp_write;
    logic [ADDR_BITS-1:0]  dp_addr;

    logic                  start_go, gen_load, accept, dp_done, bus_error;
    logic                  rd_check, mismatch, wr_adv;
    pat_t                  gen_pat;
    logic [31:0]           gen_seed, wdata, exp_data;
    logic [ADDR_BITS-1:0]  base_word, next_addr;
    logic [LEN_BITS-1:0]   next_left;
    mode_t                 start_mode;

    assign hsize_o = HSIZE_WORD;
    assign hprot_o = HPROT_DEFAULT;

    function automatic logic use_incr4(input logic [ADDR_BITS-1:0] a,
                                       input logic [LEN_BITS-1:0]  rem);
        return (a[3:0] == 4'd0) && (rem >= LEN_BITS'(4));
    endfunction

    always_comb begin
        start_go   = (state == S_IDLE) && start_i;
        gen_load   = start_go || (state == S_TURN);
        gen_pat    = start_go ? pat_t'(pat_sel_i) : pat_q;
        gen_seed   = start_go ? seed_i : seed_q;
        accept     = (state == S_ADDR) && hready_i;
        wr_adv     = accept && hwrite_o;
        dp_done    = dp_valid && hready_i;
        bus_error  = dp_valid && hresp_i && !hready_i;
        rd_check   = dp_done && !dp_write;
        mismatch   = rd_check && (hrdata_i != exp_data);
        base_word  = {base_addr_i[ADDR_BITS-1:2], 2'b00};
        start_mode = (mode_i == MODE_RSVD) ? MODE_WRITE : mode_t'(mode_i);
        next_addr  = haddr_o + ADDR_BITS'(4);
        next_left  = addr_left - 1'b1;
    end

    // Write stream follows accepted address phases; expected stream follows
    // completed read data phases, so both advance in word order.
    ahb_bist_patgen #(.ADDR_BITS(ADDR_BITS)) u_wgen (
        .clk     (hclk_i),
        .rst     (hrst_i),
        .load    (gen_load),
        .adv     (wr_adv),
        .pat_sel (gen_pat),
        .seed    (gen_seed),
        .addr    (haddr_o),
        .data    (wdata)
    );

    ahb_bist_patgen #(.ADDR_BITS(ADDR_BITS)) u_rgen (
        .clk     (hclk_i),
        .rst     (hrst_i),
        .load    (gen_load),
        .adv     (rd_check),
        .pat_sel (gen_pat),
        .seed    (gen_seed),
        .addr    (dp_addr),
        .data    (exp_data)
    );

    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            state            <= S_IDLE;
            mode_q           <= MODE_WRITE;
            pat_q            <= PAT_ADDR;
            seed_q           <= '0;
            base_q           <= '0;
            len_q            <= '0;
            addr_left        <= '0;
            beat_left        <= '0;
            dp_valid         <= 1'b0;
            dp_write         <= 1'b0;
            dp_addr          <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
            bus_err_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            hsel_o           <= 1'b0;
            haddr_o          <= '0;
            htrans_o         <= HTRANS_IDLE;
            hburst_o         <= HBURST_SINGLE;
            hwrite_o         <= 1'b0;
            hwdata_o         <= '0;
        end else begin
            done_o <= 1'b0;
            if (dp_done)
                dp_valid <= 1'b0;
            if (mismatch) begin
                err_o <= 1'b1;
                if (err_cnt_o != '1)
                    err_cnt_o <= err_cnt_o + 16'd1;
                if (err_cnt_o == '0)
                    first_err_addr_o <= dp_addr;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q           <= start_mode;
                        pat_q            <= pat_t'(pat_sel_i);
                        seed_q           <= seed_i;
                        base_q           <= base_word;
                        len_q            <= len_words_i;
                        err_o            <= 1'b0;
                        bus_err_o        <= 1'b0;
                        err_cnt_o        <= '0;
                        first_err_addr_o <= '0;
                        if (len_words_i == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= S_ADDR;
                            busy_o    <= 1'b1;
                            hsel_o    <= 1'b1;
                            haddr_o   <= base_word;
                            htrans_o  <= HTRANS_NONSEQ;
                            hburst_o  <= use_incr4(base_word, len_words_i) ? HBURST_INCR4 : HBURST_SINGLE;
                            beat_left <= use_incr4(base_word, len_words_i) ? 2'd3 : 2'd0;
                            hwrite_o  <= (start_mode != MODE_READ);
                            addr_left <= len_words_i;
                        end
                    end
                end

                S_ADDR, S_DRAIN: begin
                    if (bus_error) begin
                        htrans_o  <= HTRANS_IDLE;
                        hsel_o    <= 1'b0;
                        dp_valid  <= 1'b0;
                        bus_err_o <= 1'b1;
                        err_o     <= 1'b1;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= S_DONE;
                    end else if (state == S_ADDR) begin
                        if (accept) begin
                            dp_valid  <= 1'b1;
                            dp_write  <= hwrite_o;
                            dp_addr   <= haddr_o;
                            if (hwrite_o)
                                hwdata_o <= wdata;
                            addr_left <= next_left;
                            if (next_left == '0) begin
                                htrans_o <= HTRANS_IDLE;
                                state    <= S_DRAIN;
                            end else begin
                                haddr_o <= next_addr;
                                if (beat_left != 2'd0) begin
                                    htrans_o  <= HTRANS_SEQ;
                                    beat_left <= beat_left - 2'd1;
                                end else begin
                                    htrans_o  <= HTRANS_NONSEQ;
                                    hburst_o  <= use_incr4(next_addr, next_left) ? HBURST_INCR4 : HBURST_SINGLE;
                                    beat_left <= use_incr4(next_addr, next_left) ? 2'd3 : 2'd0;
                                end
                            end
                        end
                    end else if (dp_done) begin
                        hsel_o <= 1'b0;
                        if (mode_q == MODE_WRCHK && hwrite_o) begin
                            state <= S_TURN;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end
                end

                S_TURN: begin
                    state     <= S_ADDR;
                    hsel_o    <= 1'b1;
                    haddr_o   <= base_q;
                    htrans_o  <= HTRANS_NONSEQ;
                    hburst_o  <= use_incr4(base_q, len_q) ? HBURST_INCR4 : HBURST_SINGLE;
                    beat_left <= use_incr4(base_q, len_q) ? 2'd3 : 2'd0;
                    hwrite_o  <= 1'b0;
                    addr_left <= len_q;
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bist_master.sv
// Bench for ahb_bist_master: behavioural SRAM slave with wait/error injection,
// address-phase scoreboard and table-driven operation vectors.
module tb_ahb_bist_master;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        start;
    logic [1:0]  mode, pat_sel;
    logic [31:0] seed;
    logic [11:0] base_addr;
    logic [10:0] len_words;
    logic        busy, done, err, bus_err;
    logic [15:0] err_cnt;
    logic [11:0] first_err_addr, haddr;
    logic        hsel, hwrite, hready, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata, hrdata;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_bist_master #(.ADDR_BITS(12), .DATA_WIDTH(32), .LEN_BITS(11)) dut (
        .hclk_i           (hclk),
        .hrst_i           (hrst),
        .start_i          (start),
        .mode_i           (mode),
        .pat_sel_i        (pat_sel),
        .seed_i           (seed),
        .base_addr_i      (base_addr),
        .len_words_i      (len_words),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .bus_err_o        (bus_err),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err_addr),
        .hsel_o           (hsel),
        .haddr_o          (haddr),
        .htrans_o         (htrans),
        .hburst_o         (hburst),
        .hsize_o          (hsize),
        .hprot_o          (hprot),
        .hwrite_o         (hwrite),
        .hwdata_o         (hwdata),
        .hready_i         (hready),
        .hrdata_i         (hrdata),
        .hresp_i          (hresp)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [11:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    // ---------------- behavioural SRAM slave + scoreboard ----------------
    logic [31:0] mem [0:1023];
    logic        s_dv, s_dw;
    logic [9:0]  s_da;
    int          wait_left, err_ph, acc_cnt;
    int          stall_beat = -1;
    int          err_beat = -1;
    logic [31:0] pend_data;
    logic        bd_req = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    assign hready = (err_ph != 1) && (wait_left == 0);
    assign hresp  = (err_ph != 0);
    assign hrdata = s_dv ? mem[s_da] : 32'h0;

    always @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            s_dv      <= 1'b0;
            s_dw      <= 1'b0;
            s_da      <= '0;
            wait_left <= 0;
            err_ph    <= 0;
        end else begin
            if (bd_req) mem[bd_idx] <= bd_val;
            if (err_ph == 1) begin
                err_ph <= 2;
            end else if (wait_left > 0) begin
                wait_left <= wait_left - 1;
            end else begin
                if (err_ph == 2) err_ph <= 0;
                else if (s_dv && s_dw) begin
                    chk("hwdata", hwdata, pend_data);
                    mem[s_da] <= hwdata;
                end
                s_dv <= 1'b0;
                if (hsel && htrans[1]) begin
                    s_dv <= 1'b1;
                    s_dw <= hwrite;
                    s_da <= haddr[11:2];
                    if (acc_cnt == err_beat) err_ph <= 1;
                    else if (acc_cnt == stall_beat) wait_left <= 2;
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got addr 0x%03h htrans %0d, required no transfer", haddr, htrans);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("haddr", 32'(haddr), 32'(e.addr));
                        chk("htrans", 32'(htrans), 32'(e.trans));
                        chk("hburst", 32'(hburst), 32'(e.burst));
                        chk("hwrite", 32'(hwrite), 32'(e.write));
                        pend_data = e.data;
                    end
                end
            end
        end
    end

    // ---------------- expectation model ----------------
    function automatic void push_pass(input logic wr, input logic [1:0] pat, input logic [31:0] sd,
                                      input logic [11:0] base, input int len);
        logic [11:0] a;
        logic [31:0] l;
        logic [2:0]  bu;
        int          inb;
        beat_t       b;
        a   = {base[11:2], 2'b00};
        l   = (sd == 0) ? 32'd1 : sd;
        inb = 0;
        bu  = 3'b000;
        for (int i = 0; i < len; i++) begin
            if (inb == 0) begin
                if (a[3:0] == 4'h0 && (len - i) >= 4) begin bu = 3'b011; inb = 4; end
                else begin bu = 3'b000; inb = 1; end
                b.trans = 2'b10;
            end else begin
                b.trans = 2'b11;
            end
            inb--;
            b.addr  = a;
            b.burst = bu;
            b.write = wr;
            case (pat)
                2'd0: b.data = {20'h0, a};
                2'd1: b.data = ~{20'h0, a};
                2'd2: b.data = sd;
                default: b.data = l;
            endcase
            exp_q.push_back(b);
            l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
            a = a + 12'd4;
        end
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  pat;
        logic [31:0] seed;
        logic [11:0] base;
        int          len;
        int          corrupt;
        int          stall;
        int          errb;
        logic        exp_err;
        logic        exp_bus;
        logic [15:0] exp_cnt;
        logic [11:0] exp_first;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        bit   fin, corrupted, saw_hsel, err_next, snap_ok;
        int   ncmp;
        logic [11:0] s_addr;
        logic [1:0]  s_trans;
        logic [31:0] s_wdata;
        exp_q.delete();
        if (v.mode != 2'd1) push_pass(1'b1, v.pat, v.seed, v.base, v.len);
        if (v.mode == 2'd1 || v.mode == 2'd2) push_pass(1'b0, v.pat, v.seed, v.base, v.len);
        acc_cnt    = 0;
        stall_beat = v.stall;
        err_beat   = v.errb;
        fin = 0; corrupted = 0; saw_hsel = 0; err_next = 0; snap_ok = 0; ncmp = 0;
        s_addr = '0; s_trans = '0; s_wdata = '0;

        @(negedge hclk);
        mode = v.mode; pat_sel = v.pat; seed = v.seed; base_addr = v.base;
        len_words = 11'(v.len); start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        for (cyc = 1; cyc <= 2000; cyc++) begin
            bd_req = 1'b0;
            if (hsel) saw_hsel = 1;
            if (cyc == 1 && v.len != 0) chk($sformatf("v%0d_busy_start", idx), 32'(busy), 32'd1);
            if (err_next) begin
                chk($sformatf("v%0d_htrans_after_error", idx), 32'(htrans), 32'd0);
                err_next = 0;
            end
            if (err_ph == 1) err_next = 1;
            if (v.stall >= 0) begin
                if (!snap_ok && wait_left == 2) begin
                    snap_ok = 1; s_addr = haddr; s_trans = htrans; s_wdata = hwdata;
                end else if (snap_ok && ncmp < 2) begin
                    chk($sformatf("v%0d_stall_haddr", idx), 32'(haddr), 32'(s_addr));
                    chk($sformatf("v%0d_stall_htrans", idx), 32'(htrans), 32'(s_trans));
                    chk($sformatf("v%0d_stall_hwdata", idx), hwdata, s_wdata);
                    ncmp++;
                end
            end
            if (v.corrupt >= 0 && !corrupted && hsel && !hwrite && htrans != 2'b00) begin
                bd_idx = 10'(v.corrupt); bd_val = 32'h0; bd_req = 1'b1; corrupted = 1;
            end
            if (done) begin fin = 1; break; end
            @(negedge hclk);
        end
        bd_req = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: done_o never rose within 2000 cycles", idx);
            return;
        end
        chk($sformatf("v%0d_busy_at_done", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d_bus_err", idx), 32'(bus_err), 32'(v.exp_bus));
        chk($sformatf("v%0d_err_cnt", idx), 32'(err_cnt), 32'(v.exp_cnt));
        chk($sformatf("v%0d_first_err_addr", idx), 32'(first_err_addr), 32'(v.exp_first));
        if (v.len == 0) begin
            chk($sformatf("v%0d_len0_done_cycle", idx), 32'(cyc), 32'd1);
            chk($sformatf("v%0d_len0_hsel_seen", idx), 32'(saw_hsel), 32'd0);
        end
        if (v.stall >= 0) chk($sformatf("v%0d_stall_cycles", idx), 32'(ncmp), 32'd2);
        @(negedge hclk);
        chk($sformatf("v%0d_done_pulse_width", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_hsel_after", idx), 32'(hsel), 32'd0);
        repeat (3) @(negedge hclk);
        chk($sformatf("v%0d_htrans_idle_after", idx), 32'(htrans), 32'd0);
        if (v.errb >= 0) chk($sformatf("v%0d_beats_before_abort", idx), 32'(acc_cnt), 32'(v.errb + 1));
        else             chk($sformatf("v%0d_beats_left", idx), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        hrst = 1'b1; start = 1'b0; mode = '0; pat_sel = '0; seed = '0;
        base_addr = '0; len_words = '0;

        //           mode  pat   seed           base    len corrupt stall errb  err  bus  cnt    first
        vecs[0] = '{2'd2, 2'd0, 32'h0,         12'h000, 8,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[1] = '{2'd0, 2'd3, 32'h0,         12'h004, 5,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[2] = '{2'd1, 2'd3, 32'h0,         12'h004, 5,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[3] = '{2'd2, 2'd2, 32'hA5A5A5A5,  12'h000, 16,  8, -1, -1, 1'b1, 1'b0, 16'd1, 12'h020};
        vecs[4] = '{2'd2, 2'd1, 32'h0,         12'h040, 8,  -1,  1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[5] = '{2'd3, 2'd0, 32'h0,         12'hFFB, 4,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[6] = '{2'd1, 2'd0, 32'h0,         12'hFF8, 4,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};
        vecs[7] = '{2'd1, 2'd0, 32'h0,         12'h100, 4,  -1, -1, -1, 1'b1, 1'b0, 16'd4, 12'h100};
        vecs[8] = '{2'd2, 2'd0, 32'h0,         12'h200, 8,  -1, -1,  2, 1'b1, 1'b1, 16'd0, 12'h000};
        vecs[9] = '{2'd0, 2'd0, 32'h0,         12'h000, 0,  -1, -1, -1, 1'b0, 1'b0, 16'd0, 12'h000};

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_flags", {30'd0, err, bus_err}, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_first_err_addr", 32'(first_err_addr), 32'd0);
        chk("rst_hsel_htrans", {29'd0, hsel, htrans}, 32'd0);
        chk("rst_haddr", 32'(haddr), 32'd0);
        chk("rst_hburst_hwrite", {28'd0, hburst, hwrite}, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd2);
        chk("rst_hprot", 32'(hprot), 32'd3);
        @(negedge hclk);
        @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset asserted in the middle of an INCR4 burst.
        exp_q.delete();
        push_pass(1'b1, 2'd0, 32'h0, 12'h000, 16);
        acc_cnt = 0; stall_beat = -1; err_beat = -1;
        @(negedge hclk);
        mode = 2'd0; pat_sel = 2'd0; base_addr = 12'h000; len_words = 11'd16; start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        n = 0;
        while (htrans != 2'b11 && n < 50) begin
            @(negedge hclk);
            n++;
        end
        chk("rst_mid_reached_seq", 32'(htrans), 32'd3);
        hrst = 1'b1;
        #1;
        chk("rst_mid_htrans", 32'(htrans), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hsel", 32'(hsel), 32'd0);
        @(negedge hclk);
        hrst = 1'b0;
        exp_q.delete();
        run_vec(vecs[0], 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
